// File: rtl/rsa_exp_scheduler.sv
// LSB-first square-and-multiply sequencer for a^e mod n over one modulo-product unit
// and one time-shared Montgomery multiplier. m stays in plain form and t in Montgomery form.
module rsa_exp_scheduler #(
   parameter int W      = 256,
   parameter int E_BITS = 256,
   parameter int CNT_W  = 9
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_src_val,
   output logic              o_src_rdy,
   input  logic [W-1:0]      i_a,
   input  logic [E_BITS-1:0] i_e,
   input  logic [W-1:0]      i_n,
   output logic              o_mp_start,
   output logic [W-1:0]      o_mp_a,
   output logic [W-1:0]      o_mp_n,
   input  logic              i_mp_finish,
   input  logic [W-1:0]      i_mp_result,
   output logic              o_mont_start,
   output logic [W-1:0]      o_mont_a,
   output logic [W-1:0]      o_mont_b,
   output logic [W-1:0]      o_mont_n,
   input  logic              i_mont_finish,
   input  logic [W-1:0]      i_mont_result,
   output logic              o_result_val,
   input  logic              i_result_rdy,
   output logic [W-1:0]      o_result,
   output logic              o_busy
);

   typedef enum logic [2:0] {
      IDLE,
      MP_WAIT,
      MUL_WAIT,
      SQR_WAIT,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(E_BITS - 1);

   state_t            state;
   state_t            state_nxt;

   logic [W-1:0]      a_lat, a_nxt;
   logic [W-1:0]      n_lat, n_nxt;
   logic [W-1:0]      m, m_nxt;
   logic [W-1:0]      t, t_nxt;
   logic [W-1:0]      op_a, op_a_nxt;
   logic [W-1:0]      op_b, op_b_nxt;
   logic [W-1:0]      result_reg, result_nxt;
   logic [E_BITS-1:0] e_sh, e_nxt;
   logic [E_BITS-1:0] e_shift;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              result_val_reg, result_val_nxt;
   logic              mp_start_reg, mont_start_reg;
   logic              mp_go, mont_go;
   logic              mp_done, mont_done;

   // A finish coinciding with our own start pulse belongs to nothing we issued.
   assign mp_done   = i_mp_finish && !mp_start_reg;
   assign mont_done = i_mont_finish && !mont_start_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      a_nxt          = a_lat;
      n_nxt          = n_lat;
      e_nxt          = e_sh;
      m_nxt          = m;
      t_nxt          = t;
      cnt_nxt        = cnt;
      result_nxt     = result_reg;
      result_val_nxt = result_val_reg;
      op_a_nxt       = op_a;
      op_b_nxt       = op_b;
      mp_go          = 1'b0;
      mont_go        = 1'b0;
      e_shift        = e_sh >> 1;

      case (state)
         IDLE: begin
            if (i_src_val) begin
               a_nxt     = i_a;
               e_nxt     = i_e;
               n_nxt     = i_n;
               m_nxt     = W'(1);
               cnt_nxt   = '0;
               mp_go     = 1'b1;
               state_nxt = MP_WAIT;
            end
         end

         MP_WAIT: begin
            if (mp_done) begin
               t_nxt = i_mp_result;
               if (e_sh[0]) begin
                  state_nxt = MUL_WAIT;
                  mont_go   = 1'b1;
               end else if (e_shift == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = SQR_WAIT;
                  mont_go   = 1'b1;
               end
            end
         end

         MUL_WAIT: begin
            if (mont_done) begin
               m_nxt = i_mont_result;
               // Last set bit consumed: the trailing square would be wasted work.
               if (e_shift == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = SQR_WAIT;
                  mont_go   = 1'b1;
               end
            end
         end

         SQR_WAIT: begin
            if (mont_done) begin
               t_nxt   = i_mont_result;
               e_nxt   = e_shift;
               cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
               if (e_shift[0]) begin
                  state_nxt = MUL_WAIT;
                  mont_go   = 1'b1;
               end else if ((e_shift >> 1) != '0) begin
                  state_nxt = SQR_WAIT;
                  mont_go   = 1'b1;
               end else begin
                  state_nxt = DONE;
               end
            end
         end

         DONE: begin
            if (!result_val_reg) begin
               result_nxt     = m;
               result_val_nxt = 1'b1;
            end else if (i_result_rdy) begin
               result_val_nxt = 1'b0;
               state_nxt      = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Operands are captured with the start pulse so they stay put until finish.
      if (mont_go) begin
         op_a_nxt = (state_nxt == MUL_WAIT) ? m_nxt : t_nxt;
         op_b_nxt = t_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_lat          <= '0;
         n_lat          <= '0;
         e_sh           <= '0;
         m              <= '0;
         t              <= '0;
         cnt            <= '0;
         op_a           <= '0;
         op_b           <= '0;
         result_reg     <= '0;
         result_val_reg <= 1'b0;
         mp_start_reg   <= 1'b0;
         mont_start_reg <= 1'b0;
      end else begin
         a_lat          <= a_nxt;
         n_lat          <= n_nxt;
         e_sh           <= e_nxt;
         m              <= m_nxt;
         t              <= t_nxt;
         cnt            <= cnt_nxt;
         op_a           <= op_a_nxt;
         op_b           <= op_b_nxt;
         result_reg     <= result_nxt;
         result_val_reg <= result_val_nxt;
         mp_start_reg   <= mp_go;
         mont_start_reg <= mont_go;
      end
   end

   assign o_src_rdy    = (state == IDLE);
   assign o_busy       = (state != IDLE);
   assign o_mp_start   = mp_start_reg;
   assign o_mp_a       = a_lat;
   assign o_mp_n       = n_lat;
   assign o_mont_start = mont_start_reg;
   assign o_mont_a     = op_a;
   assign o_mont_b     = op_b;
   assign o_mont_n     = n_lat;
   assign o_result_val = result_val_reg;
   assign o_result     = result_reg;

endmodule

// File: tb/tb_rsa_exp_scheduler.sv
// Directed bench for rsa_exp_scheduler at W=16 with behavioural modulo-product and
// Montgomery units, both 4 cycles from start to finish.
module tb_rsa_exp_scheduler;

   localparam int W  = 16;
   localparam int EB = 16;
   localparam int LP = 4;
   localparam int LM = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          src_val = 1'b0;
   logic          src_rdy;
   logic [W-1:0]  a_in = '0;
   logic [EB-1:0] e_in = '0;
   logic [W-1:0]  n_in = '0;
   logic          mp_start;
   logic [W-1:0]  mp_a, mp_n;
   logic          mp_finish;
   logic [W-1:0]  mp_result;
   logic          mont_start;
   logic [W-1:0]  mont_a, mont_b, mont_n;
   logic          mont_finish;
   logic [W-1:0]  mont_result;
   logic          result_val;
   logic          result_rdy = 1'b0;
   logic [W-1:0]  result;
   logic          busy;

   logic          inj_mp = 1'b0;
   logic          inj_mont = 1'b0;

   int compared = 0;
   int mismatched = 0;

   rsa_exp_scheduler #(.W(W), .E_BITS(EB), .CNT_W(5)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_src_val(src_val), .o_src_rdy(src_rdy),
      .i_a(a_in), .i_e(e_in), .i_n(n_in),
      .o_mp_start(mp_start), .o_mp_a(mp_a), .o_mp_n(mp_n),
      .i_mp_finish(mp_finish), .i_mp_result(mp_result),
      .o_mont_start(mont_start), .o_mont_a(mont_a), .o_mont_b(mont_b), .o_mont_n(mont_n),
      .i_mont_finish(mont_finish), .i_mont_result(mont_result),
      .o_result_val(result_val), .i_result_rdy(result_rdy), .o_result(result),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mp_model(input logic [W-1:0] x, input logic [W-1:0] m);
      logic [47:0] p;
      p = {16'h0, x, 16'h0};
      return p % {32'h0, m};
   endfunction

   function automatic logic [W-1:0] mont_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [W-1:0] m);
      logic [47:0] acc;
      acc = 48'(x) * 48'(y);
      for (int i = 0; i < W; i++) begin
         if (acc[0]) acc = acc + 48'(m);
         acc = acc >> 1;
      end
      if (acc >= 48'(m)) acc = acc - 48'(m);
      return acc[W-1:0];
   endfunction

   // Behavioural arithmetic units: finish lands LP/LM cycles after the start cycle.
   logic         mp_fin_m = 1'b0;
   logic [W-1:0] mp_res_m = '0;
   int           mp_cd = 0;
   logic         mont_fin_m = 1'b0;
   logic [W-1:0] mont_res_m = '0;
   int           mont_cd = 0;

   always @(posedge clk) begin
      mp_fin_m <= 1'b0;
      if (mp_start === 1'b1) begin
         mp_cd    <= LP - 1;
         mp_res_m <= mp_model(mp_a, mp_n);
      end else if (mp_cd == 1) begin
         mp_fin_m <= 1'b1;
         mp_cd    <= 0;
      end else if (mp_cd > 1) begin
         mp_cd <= mp_cd - 1;
      end
   end

   always @(posedge clk) begin
      mont_fin_m <= 1'b0;
      if (mont_start === 1'b1) begin
         mont_cd    <= LM - 1;
         mont_res_m <= mont_model(mont_a, mont_b, mont_n);
      end else if (mont_cd == 1) begin
         mont_fin_m <= 1'b1;
         mont_cd    <= 0;
      end else if (mont_cd > 1) begin
         mont_cd <= mont_cd - 1;
      end
   end

   assign mp_finish   = mp_fin_m | inj_mp;
   assign mp_result   = inj_mp ? 16'hDEAD : mp_res_m;
   assign mont_finish = mont_fin_m | inj_mont;
   assign mont_result = inj_mont ? 16'hBEEF : mont_res_m;

   // Start log: ops shifts in 1 for multiply (A!=B) and 0 for square (A==B).
   int           mp_starts = 0;
   int           mont_starts = 0;
   logic [15:0]  ops = '0;
   logic [W-1:0] last_ma = '0;
   logic [W-1:0] last_mb = '0;

   always @(posedge clk) begin
      if (mp_start === 1'b1) mp_starts <= mp_starts + 1;
      if (mont_start === 1'b1) begin
         mont_starts <= mont_starts + 1;
         ops         <= {ops[14:0], mont_a != mont_b};
         last_ma     <= mont_a;
         last_mb     <= mont_b;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] av, input logic [EB-1:0] ev, input logic [W-1:0] nv);
      int guard;
      guard = 0;
      @(negedge clk);
      while (src_rdy !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("src_rdy_before_send", src_rdy, 1);
      a_in    = av;
      e_in    = ev;
      n_in    = nv;
      src_val = 1'b1;
      @(negedge clk);
      src_val = 1'b0;
   endtask

   // Returns in the first cycle with result_val high; lat counts from the accept cycle.
   task automatic wait_result(output int lat);
      lat = 1;
      while (result_val !== 1'b1 && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      check("result_val_seen", result_val, 1);
   endtask

   task automatic finish_job();
      result_rdy = 1'b1;
      @(negedge clk);
      result_rdy = 1'b0;
      check("idle_src_rdy", src_rdy, 1);
      check("idle_result_val", result_val, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      int mp0, mont0;
      logic [W-1:0] held, ma_snap, mb_snap;
      logic bad;

      // Reset state
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_src_rdy", src_rdy, 1);
      check("rst_result_val", result_val, 0);
      check("rst_mp_start", mp_start, 0);
      check("rst_mont_start", mont_start, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_mp_a", mp_a, 0);
      check("rst_mont_a", mont_a, 0);
      rst = 1'b0;

      // 4^13 mod 497 = 445, op order M,S,S,M,S,M
      mp0 = mp_starts; mont0 = mont_starts;
      send(16'd4, 16'd13, 16'd497);
      check("busy_after_accept", busy, 1);
      check("src_rdy_after_accept", src_rdy, 0);
      wait_result(lat);
      check("e13_result", result, 445);
      check("e13_latency", lat, 1 + (LP + 1) + 6 * (LM + 1) + 1);
      check("e13_mp_starts", mp_starts - mp0, 1);
      check("e13_mont_starts", mont_starts - mont0, 6);
      check("e13_op_order", ops[5:0], 6'b100101);
      check("e13_mp_a", mp_a, 4);
      check("e13_mp_n", mp_n, 497);
      check("e13_mont_n", mont_n, 497);
      finish_job();

      // e=0 gives 1 with no Montgomery work
      mp0 = mp_starts; mont0 = mont_starts;
      send(16'd7, 16'd0, 16'd11);
      wait_result(lat);
      check("e0_result", result, 1);
      check("e0_latency", lat, 1 + (LP + 1) + 1);
      check("e0_mp_starts", mp_starts - mp0, 1);
      check("e0_mont_starts", mont_starts - mont0, 0);
      finish_job();

      // e=1: single multiply of 1 by 9*2^16 mod 11 = 4
      mp0 = mp_starts; mont0 = mont_starts;
      send(16'd9, 16'd1, 16'd11);
      wait_result(lat);
      check("e1_result", result, 9);
      check("e1_mont_starts", mont_starts - mont0, 1);
      check("e1_mont_a", last_ma, 1);
      check("e1_mont_b", last_mb, 4);
      finish_job();

      // Held result: 3^5 mod 7 = 5; new requests ignored while result is pending
      mp0 = mp_starts;
      send(16'd3, 16'd5, 16'd7);
      wait_result(lat);
      held = result;
      check("hold_result", held, 5);
      for (int i = 0; i < 20; i++) begin
         if (i == 2) begin
            a_in = 16'd5; e_in = 16'd3; n_in = 16'd13;
            src_val = 1'b1;
         end
         @(negedge clk);
         check("hold_stable", result, held);
         check("hold_src_rdy", src_rdy, 0);
      end
      check("hold_val", result_val, 1);
      src_val = 1'b0;
      check("hold_no_new_mp", mp_starts - mp0, 1);
      finish_job();
      send(16'd2, 16'd10, 16'd1023);
      wait_result(lat);
      check("e10_result", result, 1);
      finish_job();

      // Stray finishes in the wrong wait state
      mp0 = mp_starts; mont0 = mont_starts;
      send(16'd4, 16'd13, 16'd497);
      @(negedge clk);
      ma_snap = mont_a; mb_snap = mont_b;
      inj_mont = 1'b1;
      @(negedge clk);
      inj_mont = 1'b0;
      check("stray_mont_no_start", mont_start, 0);
      check("stray_mont_a", mont_a, ma_snap);
      check("stray_mont_b", mont_b, mb_snap);
      lat = 0;
      while (!(mont_start === 1'b1 && mont_a == mont_b) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("reach_sqr_wait", mont_start, 1);
      @(negedge clk);
      ma_snap = mont_a;
      inj_mp = 1'b1;
      @(negedge clk);
      inj_mp = 1'b0;
      check("stray_mp_no_start", mont_start, 0);
      check("stray_mp_mont_a", mont_a, ma_snap);
      check("stray_mp_busy", busy, 1);
      wait_result(lat);
      check("stray_result", result, 445);
      check("stray_mp_starts", mp_starts - mp0, 1);
      check("stray_mont_starts", mont_starts - mont0, 6);
      finish_job();

      // Reset during SQR_WAIT
      send(16'd4, 16'd13, 16'd497);
      lat = 0;
      while (!(mont_start === 1'b1 && mont_a == mont_b) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_src_rdy", src_rdy, 1);
      check("midrst_busy", busy, 0);
      check("midrst_result_val", result_val, 0);
      check("midrst_mont_start", mont_start, 0);
      check("midrst_result", result, 0);
      check("midrst_mont_a", mont_a, 0);
      check("midrst_mp_a", mp_a, 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (mont_start !== 1'b0 || mp_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      check("postrst_quiet", bad, 0);
      send(16'd4, 16'd13, 16'd497);
      wait_result(lat);
      check("rerun_result", result, 445);
      finish_job();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rsa_exp_scheduler.md
Name: rsa_exp_scheduler

Overview:
Sequences one modulo-product unit and one shared Montgomery multiplier to compute a^e mod n. It uses LSB-first square-and-multiply with a single time-multiplexed Montgomery unit, so there is no separate cross/self instance. It sits between the RSA wrapper's src/result handshake and the arithmetic units and owns all operand muxing and start pulses.

Parameters:
W, 256, operand width of a, n and the result.
E_BITS, 256, exponent width.
CNT_W, 9, width of the bit-position counter; must hold E_BITS.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_src_val  in  1  a/e/n valid
o_src_rdy  out  1  scheduler accepts a/e/n
i_a  in  W  base; requires a < n
i_e  in  E_BITS  exponent
i_n  in  W  modulus; requires odd, n > 1
o_mp_start  out  1  one-cycle start pulse to modulo-product unit
o_mp_a  out  W  operand a to modulo-product unit (computes a*2^W mod n)
o_mp_n  out  W  modulus to modulo-product unit
i_mp_finish  in  1  modulo-product done pulse
i_mp_result  in  W  a*2^W mod n
o_mont_start  out  1  one-cycle start pulse to Montgomery unit
o_mont_a  out  W  Montgomery operand A
o_mont_b  out  W  Montgomery operand B
o_mont_n  out  W  modulus to Montgomery unit
i_mont_finish  in  1  Montgomery done pulse
i_mont_result  in  W  A*B*2^-W mod n
o_result_val  out  1  result valid
i_result_rdy  in  1  consumer accepts result
o_result  out  W  a^e mod n
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state IDLE; o_src_rdy=1; o_result_val=0; o_mp_start=0; o_mont_start=0; o_busy=0. o_result=0, and the internal m, t, e, n, a and counter registers are all 0.
- Registered outputs: all start pulses, o_result_val and o_result come directly from flops. o_src_rdy = (state==IDLE). o_mp_a/o_mp_n/o_mont_n are driven from the latched a and n registers.
- Operand muxing: o_mont_a/o_mont_b = (m,t) in MUL_WAIT, (t,t) in SQR_WAIT, and hold their last value elsewhere. They are stable from the start pulse until finish.
- State IDLE: on i_src_val && o_src_rdy, latch a, e, n; set m<=1 and counter<=0; assert o_mp_start on the next cycle; go to MP_WAIT.
- State MP_WAIT: on i_mp_finish, t<=i_mp_result. Then:
  - if e[0]: go to MUL_WAIT with o_mont_start pulsed.
  - else if (e>>1)==0: go to DONE.
  - else: go to SQR_WAIT with o_mont_start pulsed.
- State MUL_WAIT: on i_mont_finish, m<=i_mont_result. If (e>>1)==0, go to DONE and skip the trailing square. Else go to SQR_WAIT with o_mont_start pulsed.
- State SQR_WAIT: on i_mont_finish, t<=i_mont_result, e<=e>>1, counter<=counter+1. Next state uses the new e[0]: MUL_WAIT if set; else SQR_WAIT if (new e>>1)!=0; else DONE.
- State DONE: on entry, o_result<=m and o_result_val<=1. Hold o_result_val and o_result stable while i_result_rdy=0. On i_result_rdy, clear o_result_val and return to IDLE; o_src_rdy rises the following cycle.
- Start pulses: exactly one cycle wide, asserted in the first cycle of each wait state. A finish seen in that same cycle is ignored; the arithmetic units need at least 2 cycles.
- Stray pulses: i_mp_finish outside MP_WAIT and i_mont_finish outside MUL_WAIT/SQR_WAIT are ignored.
- Counter: saturates at E_BITS-1 and is debug-visible only. Termination is decided by e, never by the counter.
- Operation counts: e=0 → result 1, zero Montgomery operations. Montgomery operations = popcount(e) + (index of MSB of e).
- Overlap: inputs are not sampled while busy; i_src_val in non-IDLE states has no effect.
- Reset mid-operation: returns to IDLE within the asynchronous assertion, with no pulses issued. Any finish arriving after reset release is ignored.
- Latency: with mp latency Lp and mont latency Lm (start to finish), the first o_result_val cycle = 1 + (Lp+1) + k*(Lm+1) + 1 cycles after acceptance, where k = number of Montgomery operations.

Test Plan:
- W=16 with behavioural arithmetic models (Lp=Lm=4). a=4, e=13, n=497 → o_result=445; exactly 1 mp start and 6 mont starts (order M,S,S,M,S,M).
- e=0, a=7, n=11 → o_result=1; 1 mp start, 0 mont starts.
- e=1, a=9, n=11 → o_result=9; exactly one mont start with o_mont_a=1, o_mont_b=t.
- Hold i_result_rdy=0 for 20 cycles after o_result_val → o_result stable, o_src_rdy=0, a new i_src_val is ignored. Raise rdy → IDLE next cycle, second job a=2, e=10, n=1023 → 1.
- Inject i_mont_finish during MP_WAIT and i_mp_finish during SQR_WAIT → no state or register change; final result unchanged.
- Assert i_rst during SQR_WAIT of the e=13 job → outputs at reset values immediately. Later finish pulses cause nothing; a re-run returns 445.
